// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_pkg
//  Description : Shared board geometry, colours, sequencer state encoding and
//                the line-clear score table for the Tetris board logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    // Board geometry. Walls sit at x = 0 and x = COLS-1, and the floor is
    // the last row. Playable cells start one column in from the left wall.
    localparam int c_board_cols   = 12;
    localparam int c_board_rows   = 21;
    localparam int c_wall_left_x  = 0;

    // Colour written into row 0 when the board shifts down.
    localparam logic [2:0] c_empty_color = 3'd0;

    // Line-clear sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SCAN    = 3'd1,
        ST_COPY_RD = 3'd2,
        ST_COPY_WR = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_DONE    = 3'd5
    } lc_state_t;

    // Points awarded per pass, indexed by the number of rows cleared.
    localparam logic [15:0] c_score_1_line  = 16'd1;
    localparam logic [15:0] c_score_2_lines = 16'd3;
    localparam logic [15:0] c_score_3_lines = 16'd5;
    localparam logic [15:0] c_score_4_lines = 16'd8;

    // Anything beyond four rows in one pass still earns the tetris value.
    function automatic logic [15:0] score_for_lines(input logic [2:0] lines);
        case (lines)
            3'd0:    score_for_lines = 16'd0;
            3'd1:    score_for_lines = c_score_1_line;
            3'd2:    score_for_lines = c_score_2_lines;
            3'd3:    score_for_lines = c_score_3_lines;
            default: score_for_lines = c_score_4_lines;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_clear_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : line_clear_sequencer_if
//  Description : Board memory port bundle: one registered read port (data
//                valid one cycle after the address) and one write port.
//                master  - the sequencer side (drives addresses / write data)
//                slave   - the board memory side (returns read data)
//  Revision    : 1.0 - initial release
// ============================================================================
interface line_clear_sequencer_if;
    logic [4:0] rd_x;
    logic [4:0] rd_y;
    logic [2:0] rd_data;
    logic       mem_wr_en;
    logic [4:0] mem_wr_x;
    logic [4:0] mem_wr_y;
    logic [2:0] mem_wr_color;

    modport master (
        output rd_x, rd_y, mem_wr_en, mem_wr_x, mem_wr_y, mem_wr_color,
        input  rd_data
    );

    modport slave (
        input  rd_x, rd_y, mem_wr_en, mem_wr_x, mem_wr_y, mem_wr_color,
        output rd_data
    );
endinterface
`default_nettype wire

// File: rtl/row_priority_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : row_priority_encoder
//  Description : Combinational search for the lowest-on-screen (numerically
//                highest) full row above the floor.
//  Ports       : rowfull  in  ROWS  per-row full flags (floor bit ignored)
//                found    out 1     a full row exists
//                index    out 5     y of that row (0 when none)
//  Revision    : 1.0 - initial release
// ============================================================================
module row_priority_encoder #(
    parameter int ROWS = 21
) (
    input  logic [ROWS-1:0] rowfull,
    output logic            found,
    output logic [4:0]      index
);

    // The floor row always reads as full, so it is masked out up front.
    localparam logic [ROWS-1:0] c_below_floor = {1'b0, {(ROWS-1){1'b1}}};

    logic [ROWS-1:0] w_candidates;

    assign w_candidates = rowfull & c_below_floor;

    // Ascending scan: the last hit is the highest y.
    always_comb begin
        found = 1'b0;
        index = 5'd0;
        for (int y = 0; y < ROWS; y++) begin
            if (w_candidates[y]) begin
                found = 1'b1;
                index = 5'(y);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/line_clear_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : line_clear_sequencer
//  Description : After a piece locks, repeatedly finds the lowest full row and
//                shifts every row above it down by one, one cell per write,
//                until no full rows remain. Owns arbitration of the board
//                write port: the lock writer always wins and the sequencer
//                stalls its pending write.
//  Ports       : clk, reset (sync, active-low)
//                start             in   pass request (IDLE only)
//                rowfull           in   per-row full flags from the board
//                lock_wr_*         in   lock writer port, lock_wr_gnt out
//                bus               mst  board read/write port
//                busy, done        out  pass status
//                lines_cleared     out  rows cleared in last pass (sat. 7)
//                score             out  running score
//  Config      : LINE_CLEAR_SCORE_EN - enables the score accumulator; when
//                undefined the score port is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_clear_sequencer
    import tetris_pkg::*;
#(
    parameter int         COLS        = c_board_cols,
    parameter int         ROWS        = c_board_rows,
    parameter logic [2:0] EMPTY_COLOR = c_empty_color
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ROWS-1:0]        rowfull,
    input  logic                   lock_wr_req,
    input  logic [4:0]             lock_wr_x,
    input  logic [4:0]             lock_wr_y,
    input  logic [2:0]             lock_wr_color,
    output logic                   lock_wr_gnt,
    line_clear_sequencer_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             lines_cleared,
    output logic [15:0]            score
);

    localparam logic [4:0] c_first_x = 5'(c_wall_left_x + 1);
    localparam logic [4:0] c_last_x  = 5'(COLS - 2);

    lc_state_t  r_state;
    lc_state_t  w_next_state;
    logic [4:0] r_cur_x;
    logic [4:0] r_cur_y;
    logic [2:0] r_lines;
    logic [2:0] r_lines_cleared;
    logic       w_found;
    logic [4:0] w_found_y;
    logic       w_copy_last_x;

    row_priority_encoder #(
        .ROWS (ROWS)
    ) u_row_priority_encoder (
        .rowfull (rowfull),
        .found   (w_found),
        .index   (w_found_y)
    );

    assign w_copy_last_x = (r_cur_x >= c_last_x);
    assign lock_wr_gnt   = lock_wr_req;
    assign lines_cleared = r_lines_cleared;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next_state = ST_SCAN;
            ST_SCAN:    w_next_state = w_found ? ST_COPY_RD : ST_DONE;
            ST_COPY_RD: w_next_state = ST_COPY_WR;
            ST_COPY_WR: begin
                // A lock write holds us here with the read address unchanged.
                if (!lock_wr_req) begin
                    if (w_copy_last_x && (r_cur_y == 5'd0)) begin
                        w_next_state = ST_SETTLE;
                    end else begin
                        w_next_state = ST_COPY_RD;
                    end
                end
            end
            ST_SETTLE:  w_next_state = ST_SCAN;
            ST_DONE:    w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs and write-port mux
    // ------------------------------------------------------------------
    always_comb begin
        busy             = (r_state != ST_IDLE);
        done             = (r_state == ST_DONE);
        bus.rd_x         = 5'd0;
        bus.rd_y         = 5'd0;
        bus.mem_wr_en    = 1'b0;
        bus.mem_wr_x     = 5'd0;
        bus.mem_wr_y     = 5'd0;
        bus.mem_wr_color = 3'd0;

        // Row 0 has nothing above it, so no read is issued for it.
        if (((r_state == ST_COPY_RD) || (r_state == ST_COPY_WR)) && (r_cur_y != 5'd0)) begin
            bus.rd_x = r_cur_x;
            bus.rd_y = r_cur_y - 5'd1;
        end

        if (lock_wr_req) begin
            bus.mem_wr_en    = 1'b1;
            bus.mem_wr_x     = lock_wr_x;
            bus.mem_wr_y     = lock_wr_y;
            bus.mem_wr_color = lock_wr_color;
        end else if (r_state == ST_COPY_WR) begin
            bus.mem_wr_en    = 1'b1;
            bus.mem_wr_x     = r_cur_x;
            bus.mem_wr_y     = r_cur_y;
            bus.mem_wr_color = (r_cur_y == 5'd0) ? EMPTY_COLOR : bus.rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Cursor and line counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cur_x         <= 5'd0;
            r_cur_y         <= 5'd0;
            r_lines         <= 3'd0;
            r_lines_cleared <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) r_lines <= 3'd0;
                end
                ST_SCAN: begin
                    if (w_found) begin
                        r_cur_y <= w_found_y;
                        r_cur_x <= c_first_x;
                    end
                end
                ST_COPY_WR: begin
                    if (!lock_wr_req) begin
                        if (!w_copy_last_x) begin
                            r_cur_x <= r_cur_x + 5'd1;
                        end else if (r_cur_y != 5'd0) begin
                            r_cur_y <= r_cur_y - 5'd1;
                            r_cur_x <= c_first_x;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_lines != 3'd7) r_lines <= r_lines + 3'd1;
                end
                ST_DONE: begin
                    r_lines_cleared <= r_lines;
                end
                default: ;
            endcase
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] r_score;

    // Wraps modulo 2^16; only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_score <= 16'd0;
        end else if (r_state == ST_DONE) begin
            r_score <= r_score + score_for_lines(r_lines);
        end
    end

    assign score = r_score;
`else
    assign score = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_clear_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_clear_sequencer
//  Description : Self-checking bench for line_clear_sequencer. Models the
//                board memory, derives rowfull from it, and checks each pass
//                against a row-queue reference of the clearing rules.
//  Config      : LINE_CLEAR_SCORE_EN - when defined, score is expected to
//                accumulate; otherwise it is expected to stay zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_clear_sequencer;

    localparam int COLS = 12;
    localparam int ROWS = 21;
    localparam int PW   = COLS - 2;

    logic            clk;
    logic            reset;
    logic            start;
    logic [ROWS-1:0] rowfull;
    logic            lock_wr_req;
    logic [4:0]      lock_wr_x;
    logic [4:0]      lock_wr_y;
    logic [2:0]      lock_wr_color;
    logic            lock_wr_gnt;
    logic            busy;
    logic            done;
    logic [2:0]      lines_cleared;
    logic [15:0]     score;

    line_clear_sequencer_if bus ();

    line_clear_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .rowfull       (rowfull),
        .lock_wr_req   (lock_wr_req),
        .lock_wr_x     (lock_wr_x),
        .lock_wr_y     (lock_wr_y),
        .lock_wr_color (lock_wr_color),
        .lock_wr_gnt   (lock_wr_gnt),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .score         (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- board memory model ----------------
    logic [2:0] board      [ROWS][COLS];
    logic [2:0] init_board [ROWS][COLS];
    logic [2:0] exp_board  [ROWS][COLS];
    logic       load;

    always @(posedge clk) begin
        if (load) begin
            board <= init_board;
        end else if (bus.mem_wr_en && (int'(bus.mem_wr_y) < ROWS) && (int'(bus.mem_wr_x) < COLS)) begin
            board[bus.mem_wr_y][bus.mem_wr_x] <= bus.mem_wr_color;
        end
        if ((int'(bus.rd_y) < ROWS) && (int'(bus.rd_x) < COLS))
            bus.rd_data <= board[bus.rd_y][bus.rd_x];
        else
            bus.rd_data <= 3'd0;
    end

    always_comb begin
        rowfull = '0;
        for (int y = 0; y < ROWS; y++) begin
            rowfull[y] = 1'b1;
            for (int x = 1; x < COLS - 1; x++)
                if (board[y][x] == 3'd0) rowfull[y] = 1'b0;
        end
    end

    // ---------------- bookkeeping ----------------
    int n_vec;
    int n_bad;
    int m_lines;
    int m_edges;
    int m_writes;
    int score_exp;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int score_pts(input int lines);
        int n;
        n = (lines > 7) ? 7 : lines;
        case (n)
            0: return 0;
            1: return 1;
            2: return 3;
            3: return 5;
            default: return 8;
        endcase
    endfunction

    function automatic bit row_is_full(input logic [3*PW-1:0] r);
        for (int i = 0; i < PW; i++)
            if (r[i*3 +: 3] == 3'd0) return 1'b0;
        return 1'b1;
    endfunction

    // Reference: treat playable rows as a stack; delete the lowest full row,
    // drop an empty row in on top, repeat. Walls and floor never move.
    task automatic model_run();
        logic [3*PW-1:0] q[$];
        logic [3*PW-1:0] r;
        int hit;
        q.delete();
        for (int y = 0; y < ROWS - 1; y++) begin
            r = '0;
            for (int x = 1; x <= PW; x++) r[(x-1)*3 +: 3] = board[y][x];
            q.push_back(r);
        end
        m_lines  = 0;
        m_edges  = 1;
        m_writes = 0;
        do begin
            hit = -1;
            for (int y = 0; y < ROWS - 1; y++)
                if (row_is_full(q[y])) hit = y;
            if (hit >= 0) begin
                m_edges  += 2 * (hit + 1) * PW + 2;
                m_writes += (hit + 1) * PW;
                q.delete(hit);
                q.push_front('0);
                m_lines++;
            end
        end while (hit >= 0);
        exp_board = board;
        for (int y = 0; y < ROWS - 1; y++)
            for (int x = 1; x <= PW; x++)
                exp_board[y][x] = q[y][(x-1)*3 +: 3];
    endtask

    function automatic int board_diffs();
        int n;
        n = 0;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                if (board[y][x] !== exp_board[y][x]) begin
                    if (n == 0) $display("  first differing cell x=%0d y=%0d: %0d vs %0d",
                                         x, y, board[y][x], exp_board[y][x]);
                    n++;
                end
        return n;
    endfunction

    task automatic fill_board(input logic [ROWS-2:0] mask, input int mx, input int my, input int mc);
        int ex;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                if (x == 0 || x == COLS - 1 || y == ROWS - 1) init_board[y][x] = 3'd7;
                else if (mask[y])  init_board[y][x] = 3'($urandom_range(1, 7));
                else               init_board[y][x] = 3'($urandom_range(0, 7));
            end
        for (int y = 0; y < ROWS - 1; y++)
            if (!mask[y]) begin
                ex = $urandom_range(1, PW);
                if (y == my && ex == mx) ex = (mx == 1) ? 2 : 1;
                init_board[y][ex] = 3'd0;
            end
        if (my >= 0) init_board[my][mx] = 3'(mc);
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Runs one pass; optionally lets the lock writer grab the port for five
    // cycles starting at the second sequencer COPY_WR. Ends one cycle after
    // done, having pulsed start during the done cycle.
    task automatic do_pass(input string tag, input bit inject, output int edges, output int writes);
        bit got_done;
        int phase;
        int lk;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        edges    = 0;
        writes   = 0;
        phase    = 0;
        lk       = 0;
        got_done = 1'b0;
        while (!got_done && edges < 20000) begin
            @(posedge clk); #1;
            edges++;
            if (inject) begin
                case (phase)
                    1: phase = 2;
                    2: begin
                        lock_wr_req   = 1'b1;
                        lock_wr_x     = 5'd0;
                        lock_wr_y     = 5'd5;
                        lock_wr_color = 3'd5;
                        lk    = 0;
                        phase = 3;
                    end
                    3: begin
                        lk++;
                        if (lk == 5) begin
                            lock_wr_req = 1'b0;
                            phase = 4;
                        end
                    end
                    default: ;
                endcase
            end
            #1;
            if (phase == 3 && lk == 0) begin
                chk({tag, "_lock_port"}, {bus.mem_wr_en, bus.mem_wr_x, bus.mem_wr_y, bus.mem_wr_color},
                    {1'b1, 5'd0, 5'd5, 3'd5});
                chk({tag, "_lock_gnt"}, lock_wr_gnt, 1);
            end
            if (bus.mem_wr_en && !lock_wr_req) begin
                writes++;
                if (inject && phase == 0) phase = 1;
            end
            if (done) got_done = 1'b1;
        end
        if (!got_done) chk({tag, "_done_timeout"}, 0, 1);
        // Start during DONE must be ignored.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    typedef struct {
        logic [ROWS-2:0] mask;
        int mx, my, mc;
        int ex, ey, ec;
        int lines;
        int edges;
        bit inject;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int   edges;
        int   writes;
        logic [ROWS-2:0] mask;
        string tag;

        //         mask            marker(x,y,c)  expect(x,y,c)  lines edges  inject
        vecs[0] = '{20'h00000,     3, 10, 2,      3, 10, 2,      0,    1,     1'b0};
        vecs[1] = '{20'h80000,     4, 18, 3,      4, 19, 3,      1,    403,   1'b0};
        vecs[2] = '{20'hF0000,     7, 15, 6,      7, 19, 6,      4,    1609,  1'b0};
        vecs[3] = '{20'hA0000,     2, 18, 5,      2, 19, 5,      2,    785,   1'b0};
        vecs[4] = '{20'h00001,     5,  1, 4,      5,  1, 4,      1,    23,    1'b0};
        vecs[5] = '{20'h80000,     4, 18, 3,      4, 19, 3,      1,    408,   1'b1};
        vecs[6] = '{20'hFFFFF,     0, -1, 0,      1,  0, 0,      7,    8041,  1'b0};

        n_vec = 0; n_bad = 0; score_exp = 0;
        reset = 1'b0; start = 1'b0; load = 1'b0;
        lock_wr_req = 1'b0; lock_wr_x = 5'd0; lock_wr_y = 5'd0; lock_wr_color = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",     busy, 0);
        chk("rst_done",     done, 0);
        chk("rst_lines",    lines_cleared, 0);
        chk("rst_score",    score, 0);
        chk("rst_wr_en",    bus.mem_wr_en, 0);
        chk("rst_rd_addr",  {bus.rd_x, bus.rd_y}, 0);
        chk("rst_wr_bus",   {bus.mem_wr_x, bus.mem_wr_y, bus.mem_wr_color}, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // ---------------- table-driven passes ----------------
        for (int i = 0; i < 7; i++) begin
            tag = $sformatf("vec%0d", i);
            fill_board(vecs[i].mask, vecs[i].mx, vecs[i].my, vecs[i].mc);
            model_run();
            if (vecs[i].inject) exp_board[5][0] = 3'd5;
            do_pass(tag, vecs[i].inject, edges, writes);
`ifdef LINE_CLEAR_SCORE_EN
            score_exp = (score_exp + score_pts(vecs[i].lines)) % 65536;
`endif
            chk({tag, "_latency"}, edges, vecs[i].edges);
            chk({tag, "_lines"},   lines_cleared, vecs[i].lines);
            chk({tag, "_busy_after"}, busy, 0);
            chk({tag, "_seq_writes"}, writes, m_writes);
            chk({tag, "_board"},   board_diffs(), 0);
            chk({tag, "_cell"},    board[vecs[i].ey][vecs[i].ex], vecs[i].ec);
            chk({tag, "_score"},   score, score_exp);
        end

        // ---------------- reset in the middle of a copy ----------------
        fill_board(20'h80000, 0, -1, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("abort_busy_before", busy, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy",  busy, 0);
        chk("abort_wr_en", bus.mem_wr_en, 0);
        chk("abort_done",  done, 0);
        chk("abort_lines", lines_cleared, 0);
        chk("abort_score", score, 0);
        reset = 1'b1;
        score_exp = 0;
        @(posedge clk); #1;
        model_run();
        do_pass("after_abort", 1'b0, edges, writes);
`ifdef LINE_CLEAR_SCORE_EN
        score_exp = (score_exp + score_pts(m_lines)) % 65536;
`endif
        chk("after_abort_latency", edges, m_edges);
        chk("after_abort_lines",   lines_cleared, (m_lines > 7) ? 7 : m_lines);
        chk("after_abort_board",   board_diffs(), 0);
        chk("after_abort_score",   score, score_exp);

        // ---------------- randomized passes ----------------
        for (int r = 0; r < 8; r++) begin
            tag  = $sformatf("rand%0d", r);
            mask = '0;
            for (int y = 0; y < ROWS - 1; y++)
                if ($urandom_range(0, 5) == 0) mask[y] = 1'b1;
            fill_board(mask, 0, -1, 0);
            model_run();
            do_pass(tag, 1'b0, edges, writes);
`ifdef LINE_CLEAR_SCORE_EN
            score_exp = (score_exp + score_pts(m_lines)) % 65536;
`endif
            chk({tag, "_latency"},    edges, m_edges);
            chk({tag, "_lines"},      lines_cleared, (m_lines > 7) ? 7 : m_lines);
            chk({tag, "_busy_after"}, busy, 0);
            chk({tag, "_seq_writes"}, writes, m_writes);
            chk({tag, "_board"},      board_diffs(), 0);
            chk({tag, "_score"},      score, score_exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
